// File: rtl/cfg_stream_loader_if.sv
// Parallel bitstream word channel into the configuration loader (valid/ready).
// Master is the word source; slave is the loader.
interface cfg_stream_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_in, output word_valid, input  word_ready);
    modport slave  (input  word_in, input  word_valid, output word_ready);
endinterface

// File: rtl/cfg_stream_loader.sv
// Serializes a word stream LSB-first onto the config chain for CHAIN_LEN bits; first bit 1 cycle after accept.
// Backpressure: word_ready drops while the prefetch buffer is full; a starved source inserts prog_en=0 gap cycles.
module cfg_stream_loader #(
    parameter  int CHAIN_LEN = 4480,
    parameter  int WORD_W    = 32,
    localparam int RB_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic            i_prog_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_abort,
    cfg_stream_loader_if.slave s_word,
    output logic            o_prog_in,
    output logic            o_prog_en,
    input  logic            i_prog_out,
    output logic            o_busy,
    output logic            o_done,
    output logic [RB_W-1:0] o_rb_ones
);
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BC_W   = $clog2(CHAIN_LEN + 1);
    localparam int AC_W   = $clog2(NWORDS + 1);
    localparam int WB_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_sreg;
    logic [WORD_W-1:0] r_hold;
    logic              r_hold_full;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [WB_W-1:0]   r_wbit;
    logic [AC_W-1:0]   r_acc_cnt;
    logic [RB_W-1:0]   r_rb_ones;
    logic              r_busy;
    logic              r_prog_en;
    logic              r_done;

    logic w_ready;
    logic w_accept;
    logic w_last_bit;
    logic w_word_end;

    assign w_ready    = r_busy & ~r_hold_full & (r_acc_cnt < AC_W'(NWORDS));
    assign w_accept   = w_ready & s_word.word_valid;
    assign w_last_bit = (r_bit_cnt == BC_W'(CHAIN_LEN - 1));
    assign w_word_end = (r_wbit == WB_W'(WORD_W - 1));

    always_ff @(posedge i_prog_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_sreg      <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
            r_wbit      <= '0;
            r_acc_cnt   <= '0;
            r_rb_ones   <= '0;
            r_busy      <= 1'b0;
            r_prog_en   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_accept)
                r_acc_cnt <= r_acc_cnt + 1'b1;
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state     <= FETCH;
                        r_busy      <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_acc_cnt   <= '0;
                        r_rb_ones   <= '0;
                        r_hold_full <= 1'b0;
                    end
                end
                FETCH: begin
                    if (w_accept) begin
                        r_sreg    <= s_word.word_in;
                        r_wbit    <= '0;
                        r_state   <= SHIFT;
                        r_prog_en <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_sreg    <= r_sreg >> 1;
                    r_wbit    <= r_wbit + 1'b1;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (i_prog_out)
                        r_rb_ones <= r_rb_ones + 1'b1;
                    if (w_accept) begin
                        r_hold      <= s_word.word_in;
                        r_hold_full <= 1'b1;
                    end
                    if (w_last_bit) begin
                        r_state   <= DONE;
                        r_prog_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_word_end) begin
                        r_wbit <= '0;
                        if (r_hold_full) begin
                            r_sreg      <= r_hold;
                            r_hold_full <= w_accept;
                        end else if (w_accept) begin
                            // Word arriving exactly at the word boundary goes straight to the shifter.
                            r_sreg      <= s_word.word_in;
                            r_hold_full <= 1'b0;
                        end else begin
                            r_state   <= FETCH;
                            r_prog_en <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (i_abort && (r_state != IDLE)) begin
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_prog_en <= 1'b0;
                r_done    <= 1'b0;
            end
        end
    end

    assign s_word.word_ready = w_ready;
    assign o_prog_in         = r_sreg[0] & r_prog_en;
    assign o_prog_en         = r_prog_en;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_rb_ones         = r_rb_ones;
endmodule

// File: tb/tb_cfg_stream_loader.sv
// Bench for cfg_stream_loader: a default 4480-bit instance and a 100-bit instance
// with a partial final word, each driving a behavioural shift chain.
module tb_cfg_stream_loader;
    localparam int LA = 4480;
    localparam int LB = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic vld = 1'b0;
    logic [31:0] wdat = '0;
    bit dsel = 1'b0;

    always #5 clk = ~clk;

    cfg_stream_loader_if #(.WORD_W(32)) ifa ();
    cfg_stream_loader_if #(.WORD_W(32)) ifb ();
    assign ifa.word_in    = wdat;
    assign ifb.word_in    = wdat;
    assign ifa.word_valid = vld & ~dsel;
    assign ifb.word_valid = vld & dsel;

    logic pin_a, en_a, pout_a, busy_a, done_a;
    logic pin_b, en_b, pout_b, busy_b, done_b;
    logic [12:0] rb_a;
    logic [6:0]  rb_b;

    cfg_stream_loader #(.CHAIN_LEN(LA), .WORD_W(32)) dut_a (
        .i_prog_clk(clk), .i_rst(rst), .i_start(start & ~dsel), .i_abort(abort & ~dsel),
        .s_word(ifa.slave), .o_prog_in(pin_a), .o_prog_en(en_a), .i_prog_out(pout_a),
        .o_busy(busy_a), .o_done(done_a), .o_rb_ones(rb_a));

    cfg_stream_loader #(.CHAIN_LEN(LB), .WORD_W(32)) dut_b (
        .i_prog_clk(clk), .i_rst(rst), .i_start(start & dsel), .i_abort(abort & dsel),
        .s_word(ifb.slave), .o_prog_in(pin_b), .o_prog_en(en_b), .i_prog_out(pout_b),
        .o_busy(busy_b), .o_done(done_b), .o_rb_ones(rb_b));

    // Behavioural configuration chains: shift on each edge where prog_en is high.
    logic [LA-1:0] chain_a = '0;
    logic [LB-1:0] chain_b = '0;
    always @(posedge clk) if (en_a) chain_a <= {chain_a[LA-2:0], pin_a};
    always @(posedge clk) if (en_b) chain_b <= {chain_b[LB-2:0], pin_b};
    assign pout_a = chain_a[LA-1];
    assign pout_b = chain_b[LB-1];

    logic m_en, m_pin, m_busy, m_done, m_rdy;
    int   m_rb;
    assign m_en   = dsel ? en_b   : en_a;
    assign m_pin  = dsel ? pin_b  : pin_a;
    assign m_busy = dsel ? busy_b : busy_a;
    assign m_done = dsel ? done_b : done_a;
    assign m_rdy  = dsel ? ifb.word_ready : ifa.word_ready;
    assign m_rb   = dsel ? int'(rb_b) : int'(rb_a);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int en_cnt, hs_cnt, gaps, done_cnt, done_lat, first_hs, first_en;
    bit q[$];

    // mode 0: full load, 1: abort after `at` bits, 2: async reset after `at` bits
    task automatic do_load(input bit sel, input logic [31:0] base, input logic [31:0] step,
                           input int period, input int mode, input int at);
        int L, nw, k, idx, timer, post, budget;
        bit finished, acc, prev_en, rst_rel;
        L = sel ? LB : LA;
        nw = (L + 31) / 32;
        budget = 12 * L + 200;
        en_cnt = 0; hs_cnt = 0; gaps = 0; done_cnt = 0; done_lat = -1;
        first_hs = -1; first_en = -1; q.delete();
        k = 1; idx = 0; timer = 0; post = -1; finished = 0; prev_en = 0; rst_rel = 0;
        dsel = sel;
        vld = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!finished) begin
            if (period == 0) vld = 1'b1;
            else vld = (idx < nw) && (timer >= period - 1);
            wdat = base + step * idx;
            @(negedge clk);
            if (k == 1) begin
                check_int("fetch_busy", int'(m_busy), 1);
                check_int("fetch_ready", int'(m_rdy), 1);
            end
            if (m_en) begin
                if (first_en < 0) first_en = k;
                if (en_cnt > 0 && !prev_en) gaps++;
                en_cnt++;
                q.push_back(m_pin);
            end
            prev_en = m_en;
            acc = vld && m_rdy;
            if (acc) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = k;
            end
            if (m_done) begin
                done_cnt++;
                if (done_lat < 0) done_lat = k;
                if (post < 0) post = 4;
            end
            if (mode == 1 && m_en && en_cnt == at) begin
                abort = 1'b1;
                post = 10;
            end
            if (mode == 2 && m_en && en_cnt == at) begin
                #2 rst = 1'b0;
                #1;
                check_int("rst_prog_en", int'(m_en), 0);
                check_int("rst_busy", int'(m_busy), 0);
                check_int("rst_ready", int'(m_rdy), 0);
                check_int("rst_prog_in", int'(m_pin), 0);
                check_int("rst_rb_ones", m_rb, 0);
                rst_rel = 1;
                post = 3;
            end
            @(posedge clk); #1;
            if (rst_rel) begin
                rst = 1'b1;
                rst_rel = 0;
            end
            if (abort) begin
                abort = 1'b0;
                check_int("abort_prog_en", int'(m_en), 0);
                check_int("abort_busy", int'(m_busy), 0);
            end
            if (acc) begin
                idx++;
                timer = 0;
            end else begin
                timer++;
            end
            if (post > 0) post--;
            if (post == 0) finished = 1;
            k++;
            if (k > budget) begin
                check_int("load_timeout", k, budget);
                finished = 1;
            end
        end
        vld = 1'b0;
    endtask

    task automatic check_stream(input int L, input logic [31:0] base, input logic [31:0] step);
        int bad;
        logic [31:0] w;
        bad = 0;
        for (int i = 0; i < q.size(); i++) begin
            w = base + step * (i / 32);
            if (q[i] != w[i % 32]) bad++;
        end
        check_int("stream_bits_wrong", bad, 0);
        check_int("stream_len", q.size(), L);
    endtask

    typedef struct {
        logic [31:0] base;
        logic [31:0] step;
        int          period;
        int          exp_en;
        int          exp_hs;
        int          exp_contig;
        int          exp_rb;
        int          exp_lat;
    } vec_t;

    vec_t tbl[5];

    initial begin
        // rb_ones of a load = ones held in the chain from the previous load.
        // Pattern 0xA5A50000+i, i<140: 140*8 + sum(popcount(i)) = 1120 + 480 = 1600.
        tbl[0] = '{32'hA5A5_0000, 32'd1, 0,  LA, 140, 1, 0,    LA + 2};
        tbl[1] = '{32'hA5A5_0000, 32'd1, 40, LA, 140, 0, 1600, -1};
        tbl[2] = '{32'hFFFF_FFFF, 32'd0, 0,  LA, 140, 1, 1600, LA + 2};
        tbl[3] = '{32'h0000_0000, 32'd0, 0,  LA, 140, 1, LA,   LA + 2};
        tbl[4] = '{32'h0000_0000, 32'd0, 0,  LA, 140, 1, 0,    LA + 2};

        #12;
        check_int("reset_busy", int'(busy_a), 0);
        check_int("reset_prog_en", int'(en_a), 0);
        check_int("reset_ready", int'(ifa.word_ready), 0);
        check_int("reset_done", int'(done_a), 0);
        check_int("reset_rb_ones", int'(rb_a), 0);
        check_int("reset_prog_in", int'(pin_a), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Words offered while idle must not be taken.
        vld = 1'b1;
        @(negedge clk);
        check_int("idle_ready", int'(ifa.word_ready), 0);
        @(posedge clk); #1;
        vld = 1'b0;

        for (int i = 0; i < 5; i++) begin
            do_load(1'b0, tbl[i].base, tbl[i].step, tbl[i].period, 0, 0);
            check_int($sformatf("row%0d_en_cycles", i), en_cnt, tbl[i].exp_en);
            check_int($sformatf("row%0d_handshakes", i), hs_cnt, tbl[i].exp_hs);
            check_int($sformatf("row%0d_contiguous", i), int'(gaps == 0), tbl[i].exp_contig);
            check_int($sformatf("row%0d_rb_ones", i), int'(rb_a), tbl[i].exp_rb);
            check_int($sformatf("row%0d_done_pulses", i), done_cnt, 1);
            check_int($sformatf("row%0d_first_bit_lat", i), first_en - first_hs, 1);
            if (tbl[i].exp_lat >= 0)
                check_int($sformatf("row%0d_done_lat", i), done_lat, tbl[i].exp_lat);
            check_stream(LA, tbl[i].base, tbl[i].step);
        end

        // Partial final word: only 4 bits of word 3 go out; its upper ones are dropped.
        do_load(1'b1, 32'hFFFF_FFF0, 32'd1, 0, 0, 0);
        check_int("part_en_cycles", en_cnt, LB);
        check_int("part_handshakes", hs_cnt, 4);
        check_int("part_done_lat", done_lat, LB + 2);
        check_int("part_rb_ones", int'(rb_b), 0);
        check_stream(LB, 32'hFFFF_FFF0, 32'd1);

        // Abort at bit 1000 of a zero load over an all-ones chain.
        do_load(1'b0, 32'hFFFF_FFFF, 32'd0, 0, 0, 0);
        check_int("ones_rb_ones", int'(rb_a), 0);
        do_load(1'b0, 32'h0, 32'd0, 0, 1, 1000);
        check_int("abort_en_cycles", en_cnt, 1000);
        check_int("abort_no_done", done_cnt, 0);
        check_int("abort_rb_partial", int'(rb_a), 1000);
        do_load(1'b0, 32'h0, 32'd0, 0, 0, 0);
        check_int("post_abort_en", en_cnt, LA);
        check_int("post_abort_hs", hs_cnt, 140);
        check_int("post_abort_done_lat", done_lat, LA + 2);
        check_int("post_abort_rb", int'(rb_a), LA - 1000);

        // Reset lands mid-cycle of bit 500, so only 499 ones reach the chain.
        do_load(1'b0, 32'hFFFF_FFFF, 32'd0, 0, 2, 500);
        do_load(1'b0, 32'h0, 32'd0, 0, 0, 0);
        check_int("post_rst_en", en_cnt, LA);
        check_int("post_rst_hs", hs_cnt, 140);
        check_int("post_rst_done_lat", done_lat, LA + 2);
        check_int("post_rst_rb", int'(rb_a), 499);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
